// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider: channel state
// encoding, the minimum usable ratio and the ratio clamp.
package clk_div_pkg;

   // Smallest ratio that produces a real high and low phase.
   localparam logic [31:0] RATIO_MIN = 32'd2;

   // Per-channel divider state.
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } ch_state_e;

   // Clamp a requested ratio: 0 and 1 behave as RATIO_MIN, anything else passes.
   // Works on a 32-bit container so any channel ratio width up to 32 fits.
   function automatic logic [31:0] eff_ratio(input logic [31:0] ratio);
      logic [31:0] r;
      if (ratio >= RATIO_MIN) begin
         r = ratio;
      end else begin
         r = RATIO_MIN;
      end
      return r;
   endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: IDLE/RUN FSM, period counter and shadow ratio.
// The ratio is captured only when a period starts, so a period always
// completes with the ratio it began with. RATIO_W must not exceed 32.
module clk_div_channel
   import clk_div_pkg::*;
#(
   parameter int RATIO_W = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               enable_i,
   input  logic [RATIO_W-1:0] ratio_i,
   output logic               divided_clk_o,
   output logic               div_tick_o,
   output logic               ch_active_o
);

   ch_state_e          state_q,  state_d;
   logic [RATIO_W-1:0] cnt_q,    cnt_d;
   logic [RATIO_W-1:0] shadow_q, shadow_d;
   logic               clk_q,    clk_d;
   logic               tick_q,   tick_d;
   logic               active_q, active_d;

   logic [RATIO_W-1:0] eff_s;
   logic [RATIO_W-1:0] half_s;
   logic [RATIO_W-1:0] cnt_inc_s;
   logic               last_s;

   // Clamped ratio, high-phase length and end-of-period detect.
   always_comb begin
      eff_s     = RATIO_W'(eff_ratio(32'(ratio_i)));
      half_s    = shadow_q >> 1;
      cnt_inc_s = cnt_q + RATIO_W'(1);
      last_s    = (cnt_q == (shadow_q - RATIO_W'(1)));
   end

   // Next-state and next-output logic for the channel FSM.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      clk_d    = clk_q;
      tick_d   = 1'b0;
      active_d = active_q;
      case (state_q)
         IDLE: begin
            if (enable_i) begin
               state_d  = RUN;
               shadow_d = eff_s;
               cnt_d    = {RATIO_W{1'b0}};
               clk_d    = 1'b1;
               tick_d   = 1'b1;
               active_d = 1'b1;
            end else begin
               cnt_d    = {RATIO_W{1'b0}};
               clk_d    = 1'b0;
               active_d = 1'b0;
            end
         end
         RUN: begin
            if (last_s) begin
               if (enable_i) begin
                  // Start the next period with a freshly sampled ratio.
                  cnt_d    = {RATIO_W{1'b0}};
                  shadow_d = eff_s;
                  clk_d    = 1'b1;
                  tick_d   = 1'b1;
               end else begin
                  // Park low; the output is already low in the last cycle.
                  state_d  = IDLE;
                  cnt_d    = {RATIO_W{1'b0}};
                  clk_d    = 1'b0;
                  active_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_inc_s;
               clk_d = (cnt_inc_s < half_s);
            end
         end
         default: begin
            state_d  = IDLE;
            cnt_d    = {RATIO_W{1'b0}};
            shadow_d = {RATIO_W{1'b0}};
            clk_d    = 1'b0;
            active_d = 1'b0;
         end
      endcase
   end

   // State, counter and registered outputs; reset clears everything at once.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= {RATIO_W{1'b0}};
         shadow_q <= {RATIO_W{1'b0}};
         clk_q    <= 1'b0;
         tick_q   <= 1'b0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         clk_q    <= clk_d;
         tick_q   <= tick_d;
         active_q <= active_d;
      end
   end

   assign divided_clk_o = clk_q;
   assign div_tick_o    = tick_q;
   assign ch_active_o   = active_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel integer clock divider: NUM_CH independent channels driven
// from one reference clock, each with its own run request and ratio.
module clk_div_multi
   import clk_div_pkg::*;
#(
   parameter int NUM_CH  = 4,
   parameter int RATIO_W = 8
) (
   input  logic                      ref_clk,
   input  logic                      reset,
   input  logic [NUM_CH-1:0]         enable,
   input  logic [NUM_CH*RATIO_W-1:0] division_ratio,
   output logic [NUM_CH-1:0]         divided_clk,
   output logic [NUM_CH-1:0]         div_tick,
   output logic [NUM_CH-1:0]         ch_active
);

   for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
      clk_div_channel #(
         .RATIO_W (RATIO_W)
      ) u_ch (
         .clk_i         (ref_clk),
         .rst_i         (reset),
         .enable_i      (enable[g]),
         .ratio_i       (division_ratio[g*RATIO_W +: RATIO_W]),
         .divided_clk_o (divided_clk[g]),
         .div_tick_o    (div_tick[g]),
         .ch_active_o   (ch_active[g])
      );
   end

endmodule
